// File: rtl/avalon_reg_bank.sv
// avalon_reg_bank
//   Avalon-MM slave register bank of NUM_REGS registers, each DATA_W bits wide.
//   A register is read/write with byte enables, read-only (shows a live status
//   input), or sticky write-1-to-clear. Reads return one cycle after the request.
//
// Ports
//   csi_MCLK_clk            clock
//   rsi_MRST_reset_n        asynchronous active-low reset
//   avs_regs_*              Avalon-MM slave: address, writedata, byteenable,
//                           write, read, readdata, readdatavalid, waitrequest
//   coe_hw_status           per-register live values for read-only registers
//   coe_hw_set              per-register, per-bit set pulses for W1C registers
//   coe_reg_q               current value of every register
//   coe_wr_strobe           one-cycle pulse per write beat, per register
//   ins_irq_irq             OR of all W1C register bits
module avalon_reg_bank #(
    parameter int                         DATA_W    = 32,
    parameter int                         NUM_REGS  = 8,
    parameter int                         ADDR_W    = 3,
    parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK  = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         csi_MCLK_clk,
    input  logic                         rsi_MRST_reset_n,
    input  logic [ADDR_W-1:0]            avs_regs_address,
    input  logic [DATA_W-1:0]            avs_regs_writedata,
    input  logic [DATA_W/8-1:0]          avs_regs_byteenable,
    input  logic                         avs_regs_write,
    input  logic                         avs_regs_read,
    output logic [DATA_W-1:0]            avs_regs_readdata,
    output logic                         avs_regs_readdatavalid,
    output logic                         avs_regs_waitrequest,
    input  logic [NUM_REGS*DATA_W-1:0]   coe_hw_status,
    input  logic [NUM_REGS*DATA_W-1:0]   coe_hw_set,
    output logic [NUM_REGS*DATA_W-1:0]   coe_reg_q,
    output logic [NUM_REGS-1:0]          coe_wr_strobe,
    output logic                         ins_irq_irq
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0]   be_mask;
    logic [DATA_W-1:0]   wdata_masked;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] w1c_any;
    logic [DATA_W-1:0]   rd_mux;

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            be_mask[b*8 +: 8] = {8{avs_regs_byteenable[b]}};
        end
    end

    assign wdata_masked = avs_regs_writedata & be_mask;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam logic [DATA_W-1:0] RST = RESET_VAL[r*DATA_W +: DATA_W];

        // Out-of-range addresses never match any r, so they produce no hit.
        assign wr_hit[r] = avs_regs_write && (avs_regs_address == ADDR_W'(r));

        if (RO_MASK[r]) begin : g_ro
            logic unused_set;
            assign unused_set = ^coe_hw_set[r*DATA_W +: DATA_W];
            assign coe_reg_q[r*DATA_W +: DATA_W] = coe_hw_status[r*DATA_W +: DATA_W];
            assign w1c_any[r] = 1'b0;
        end else begin : g_store
            logic [DATA_W-1:0] store;
            logic              unused_status;
            assign unused_status = ^coe_hw_status[r*DATA_W +: DATA_W];

            if (W1C_MASK[r]) begin : g_w1c
                // Set is OR-ed in after the clear, so a set wins on the same bit.
                always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
                    if (!rsi_MRST_reset_n) begin
                        store <= RST;
                    end else begin
                        store <= (store & ~(wr_hit[r] ? wdata_masked : '0))
                               | coe_hw_set[r*DATA_W +: DATA_W];
                    end
                end
                assign w1c_any[r] = |store;
            end else begin : g_rw
                logic unused_set;
                assign unused_set = ^coe_hw_set[r*DATA_W +: DATA_W];
                always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
                    if (!rsi_MRST_reset_n) begin
                        store <= RST;
                    end else if (wr_hit[r]) begin
                        store <= (store & ~be_mask) | wdata_masked;
                    end
                end
                assign w1c_any[r] = 1'b0;
            end

            assign coe_reg_q[r*DATA_W +: DATA_W] = store;
        end
    end

    // Unmatched addresses fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (avs_regs_address == ADDR_W'(r)) begin
                rd_mux = coe_reg_q[r*DATA_W +: DATA_W];
            end
        end
    end

    // rd_mux reflects storage before this edge's write, giving read-before-write.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            avs_regs_readdata      <= '0;
            avs_regs_readdatavalid <= 1'b0;
            coe_wr_strobe          <= '0;
        end else begin
            avs_regs_readdatavalid <= avs_regs_read;
            coe_wr_strobe          <= wr_hit;
            if (avs_regs_read) begin
                avs_regs_readdata <= rd_mux;
            end
        end
    end

    assign avs_regs_waitrequest = 1'b0;
    assign ins_irq_irq          = |w1c_any;

endmodule

// File: tb/tb_avalon_reg_bank.sv
module tb_avalon_reg_bank;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 3;
    localparam logic [NUM_REGS-1:0] RO_MASK  = 5'b01000;
    localparam logic [NUM_REGS-1:0] W1C_MASK = 5'b01010;
    localparam logic [NUM_REGS*DATA_W-1:0] RESET_VAL =
        {32'h0000_BEEF, 32'h5555_5555, 32'hA5A5_0001, 32'h0000_0000, 32'h0000_00C3};

    logic                        clk;
    logic                        rst_n;
    logic [ADDR_W-1:0]           address;
    logic [DATA_W-1:0]           writedata;
    logic [DATA_W/8-1:0]         byteenable;
    logic                        write;
    logic                        read;
    logic [DATA_W-1:0]           readdata;
    logic                        readdatavalid;
    logic                        waitrequest;
    logic [NUM_REGS*DATA_W-1:0]  hw_status;
    logic [NUM_REGS*DATA_W-1:0]  hw_set;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;
    logic [NUM_REGS-1:0]         wr_strobe;
    logic                        irq;

    avalon_reg_bank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .RO_MASK(RO_MASK), .W1C_MASK(W1C_MASK), .RESET_VAL(RESET_VAL)
    ) dut (
        .csi_MCLK_clk           (clk),
        .rsi_MRST_reset_n       (rst_n),
        .avs_regs_address       (address),
        .avs_regs_writedata     (writedata),
        .avs_regs_byteenable    (byteenable),
        .avs_regs_write         (write),
        .avs_regs_read          (read),
        .avs_regs_readdata      (readdata),
        .avs_regs_readdatavalid (readdatavalid),
        .avs_regs_waitrequest   (waitrequest),
        .coe_hw_status          (hw_status),
        .coe_hw_set             (hw_set),
        .coe_reg_q              (reg_q),
        .coe_wr_strobe          (wr_strobe),
        .ins_irq_irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]         m_reg [NUM_REGS];
    logic [31:0]         exp_rdata;
    logic                exp_valid;
    logic [NUM_REGS-1:0] exp_strobe;
    int                  stb_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] ro_bits;
    logic [NUM_REGS-1:0] w1c_bits;
    logic [NUM_REGS*DATA_W-1:0] rst_vec;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_live(input int r);
        if (r >= NUM_REGS) return 32'h0;
        if (ro_bits[r]) return hw_status[r*32 +: 32];
        return m_reg[r];
    endfunction

    function automatic logic exp_irq();
        logic any = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            if (w1c_bits[r] && !ro_bits[r] && m_reg[r] != 0) any = 1'b1;
        return any;
    endfunction

    task automatic check_outputs();
        check_val("valid", 32'(readdatavalid), 32'(exp_valid));
        check_val("rdata", readdata, exp_rdata);
        check_val("strobe", 32'(wr_strobe), 32'(exp_strobe));
        check_val("irq", 32'(irq), 32'(exp_irq()));
        check_val("waitreq", 32'(waitrequest), 32'h0);
        for (int r = 0; r < NUM_REGS; r++)
            check_val($sformatf("q%0d", r), reg_q[r*32 +: 32], exp_live(r));
    endtask

    task automatic idle();
        write = 1'b0; read = 1'b0; hw_set = '0;
    endtask

    // Apply the current inputs across one clock edge and compare every output.
    task automatic cycle();
        int a;
        logic [31:0] nv;
        a = int'(address);
        exp_valid = read;
        if (read) exp_rdata = exp_live(a);
        exp_strobe = '0;
        if (write && a < NUM_REGS) exp_strobe[a] = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (ro_bits[r]) continue;
            if (w1c_bits[r]) begin
                for (int i = 0; i < 32; i++) begin
                    if (hw_set[r*32 + i]) nv[i] = 1'b1;
                    else if (write && a == r && byteenable[i/8] && writedata[i]) nv[i] = 1'b0;
                    else nv[i] = m_reg[r][i];
                end
                m_reg[r] = nv;
            end else if (write && a == r) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_reg[r][b*8 +: 8] = writedata[b*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        for (int r = 0; r < NUM_REGS; r++)
            if (wr_strobe[r]) stb_cnt[r]++;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < NUM_REGS; r++) m_reg[r] = rst_vec[r*32 +: 32];
        exp_rdata  = '0;
        exp_valid  = 1'b0;
        exp_strobe = '0;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] be);
        idle();
        address = ADDR_W'(a); writedata = d; byteenable = be; write = 1'b1;
        cycle();
    endtask

    task automatic do_read(input int a);
        idle();
        address = ADDR_W'(a); read = 1'b1;
        cycle();
    endtask

    initial begin
        ro_bits  = RO_MASK;
        w1c_bits = W1C_MASK;
        rst_vec  = RESET_VAL;
        rst_n = 1'b1;
        address = '0; writedata = '0; byteenable = '0;
        hw_status = '0;
        idle();
        for (int r = 0; r < NUM_REGS; r++) stb_cnt[r] = 0;
        hw_status[3*32 +: 32] = 32'h0BAD_F00D;
        #2;
        apply_reset();
        check_val("rst_q2", reg_q[2*32 +: 32], 32'hA5A5_0001);
        check_val("rst_q0", reg_q[0 +: 32], 32'h0000_00C3);

        // 1: reset value readback, valid for exactly one cycle
        do_read(2);
        check_val("t1_rdata", readdata, 32'hA5A5_0001);
        check_val("t1_valid", 32'(readdatavalid), 32'h1);
        idle(); cycle();
        check_val("t1_valid_drop", 32'(readdatavalid), 32'h0);

        // 2: RW byte enables
        for (int r = 0; r < NUM_REGS; r++) stb_cnt[r] = 0;
        do_write(0, 32'h1122_3344, 4'hF);
        do_write(0, 32'hFFFF_FFFF, 4'b0101);
        do_read(0);
        check_val("t2_rdata", readdata, 32'h11FF_33FF);
        check_val("t2_strobes", 32'(stb_cnt[0]), 32'd2);

        // 3: W1C set / clear / set-wins
        idle(); hw_set[1*32 +: 32] = 32'h0000_00F0; cycle();
        check_val("t3_set", reg_q[32 +: 32], 32'h0000_00F0);
        check_val("t3_irq", 32'(irq), 32'h1);
        do_write(1, 32'h0000_0030, 4'hF);
        check_val("t3_clr", reg_q[32 +: 32], 32'h0000_00C0);
        idle(); address = 3'd1; writedata = 32'h0000_00C0; byteenable = 4'hF; write = 1'b1;
        hw_set[1*32 +: 32] = 32'h0000_0080;
        cycle();
        check_val("t3_setwins", reg_q[32 +: 32], 32'h0000_0080);
        check_val("t3_irq_hold", 32'(irq), 32'h1);

        // 4: RO register ignores writes but still strobes
        hw_status[3*32 +: 32] = 32'hDEAD_BEEF;
        do_write(3, 32'h0, 4'hF);
        check_val("t4_strobe3", 32'(wr_strobe[3]), 32'h1);
        do_read(3);
        check_val("t4_rdata", readdata, 32'hDEAD_BEEF);

        // 5: out-of-range address
        do_write(6, 32'h0000_1234, 4'hF);
        check_val("t5_strobe", 32'(wr_strobe), 32'h0);
        do_read(6);
        check_val("t5_rdata", readdata, 32'h0);
        check_val("t5_valid", 32'(readdatavalid), 32'h1);

        // 6: back-to-back reads, then reset mid-stream
        do_read(0);
        check_val("t6_b0", readdata, 32'h11FF_33FF);
        do_read(1);
        check_val("t6_b1", readdata, 32'h0000_0080);
        do_read(2);
        check_val("t6_b2", readdata, 32'hA5A5_0001);
        check_val("t6_v2", 32'(readdatavalid), 32'h1);
        #2;
        apply_reset();
        check_val("t6_rst_q0", reg_q[0 +: 32], 32'h0000_00C3);
        check_val("t6_rst_q1", reg_q[32 +: 32], 32'h0);

        // randomized traffic against the model
        for (int it = 0; it < 600; it++) begin
            idle();
            address    = ADDR_W'($urandom_range(0, 7));
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            write      = 1'($urandom_range(0, 1));
            read       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) hw_set = {5{$urandom & $urandom}};
            hw_status  = {5{$urandom}};
            cycle();
            if (it == 300) begin
                #2;
                apply_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
